// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// The configuration macro ALU_ARB_FIXED_PRIO_EN selects fixed-priority grant instead of round-robin.
package alu_arb_pkg;

    localparam int W_DEF   = 4;
    localparam int OPW_DEF = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

    function automatic logic [1:0] id2oh(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: a, b (W bits) and select s -> y (2W bits).
// Ops: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6 concat {a,b}, 7 shift a left by b.
module alu #(
    parameter int W   = 4,
    parameter int OPW = 3
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] s,
    output logic [2*W-1:0] y
);

    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;

    assign ax = (2*W)'(a);
    assign bx = (2*W)'(b);

    always_comb begin
        y = '0;
        case (s)
            OPW'(0): y = ax + bx;
            OPW'(1): y = ax - bx;
            OPW'(2): y = ax * bx;
            OPW'(3): y = ax & bx;
            OPW'(4): y = ax | bx;
            OPW'(5): y = ax ^ bx;
            OPW'(6): y = {a, b};
            OPW'(7): y = ax << b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb_rr.sv
// Two-input grant: round-robin by default, fixed priority (requester 0 wins)
// when ALU_ARB_FIXED_PRIO_EN is defined. Grant outputs are combinational.
module alu_arb_rr
    import alu_arb_pkg::*;
(
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic    clk,
    input  logic    rst_n,
    input  logic    accept_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output req_id_t    gnt_id_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_id_o = req_i[0] ? 1'b0 : 1'b1;
        gnt_o    = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
    end
`else
    // prio_q names the requester that wins a tie; it moves only on an accepted transfer.
    req_id_t prio_q;

    always_comb begin
        if (req_i == 2'b11) begin
            gnt_id_o = prio_q;
        end else begin
            gnt_id_o = req_i[0] ? 1'b0 : 1'b1;
        end
        gnt_o = (req_i == 2'b00) ? 2'b00 : id2oh(gnt_id_o);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (accept_i) begin
            prio_q <= ~gnt_id_o;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE -> EXEC -> RESP handshake FSM.
// ALU_ARB_FIXED_PRIO_EN switches the grant policy to fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0][W-1:0]     req_a_i,
    input  logic [1:0][W-1:0]     req_b_i,
    input  logic [1:0][OPW-1:0]   req_op_i,
    output logic [1:0]            rsp_valid_o,
    input  logic [1:0]            rsp_ready_i,
    output logic [2*W-1:0]        rsp_y_o,
    output logic [1:0][CNT_W-1:0] done_cnt_o,
    output logic                  busy_o
);

    state_e                  state_q;
    req_id_t                 id_q;
    logic [W-1:0]            a_q;
    logic [W-1:0]            b_q;
    logic [OPW-1:0]          op_q;
    logic [2*W-1:0]          rsp_y_q;
    logic [1:0]              rsp_valid_q;
    logic [1:0][CNT_W-1:0]   done_cnt_q;

    logic [1:0]              gnt;
    req_id_t                 gnt_id;
    logic                    accept;
    logic [2*W-1:0]          alu_y;

    assign accept      = (state_q == IDLE) && (gnt != 2'b00);
    assign req_ready_o = (state_q == IDLE) ? gnt : 2'b00;

    alu_arb_rr u_grant (
`ifndef ALU_ARB_FIXED_PRIO_EN
        .clk      (clk),
        .rst_n    (rst_n),
        .accept_i (accept),
`endif
        .req_i    (req_valid_i),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // The ALU only ever sees latched operands, so requesters may change req_* freely after acceptance.
    alu #(.W(W), .OPW(OPW)) u_alu (
        .a (a_q),
        .b (b_q),
        .s (op_q),
        .y (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_y_q     <= '0;
            rsp_valid_q <= 2'b00;
            done_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= req_a_i[gnt_id];
                        b_q     <= req_b_i[gnt_id];
                        op_q    <= req_op_i[gnt_id];
                        id_q    <= gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_q     <= alu_y;
                    rsp_valid_q <= id2oh(id_q);
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i[id_q]) begin
                        rsp_valid_q        <= 2'b00;
                        done_cnt_q[id_q]   <= done_cnt_q[id_q] + 8'd1;
                        state_q            <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_y_o     = rsp_y_q;
    assign done_cnt_o  = done_cnt_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed and random transactions against a
// transaction-level model (ALU arithmetic, grant policy, completion counters).
module tb_alu_arbiter;

    localparam int W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            req_valid_i;
    logic [1:0]            req_ready_o;
    logic [1:0][W-1:0]     req_a_i;
    logic [1:0][W-1:0]     req_b_i;
    logic [1:0][2:0]       req_op_i;
    logic [1:0]            rsp_valid_o;
    logic [1:0]            rsp_ready_i;
    logic [2*W-1:0]        rsp_y_o;
    logic [1:0][7:0]       done_cnt_o;
    logic                  busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt[2];
    int prio;

    alu_arbiter #(.W(W), .OPW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_y_o     (rsp_y_o),
        .done_cnt_o  (done_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic int alu_ref(input int a, input int b, input int op);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (a * b) % 256;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return a * 16 + b;
            default: return (a << b) % 256;
        endcase
    endfunction

    function automatic int next_grant(input logic [1:0] vld);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return vld[0] ? 0 : 1;
`else
        if (vld == 2'b11) return prio;
        return vld[0] ? 0 : 1;
`endif
    endfunction

    task automatic note_grant(input int g);
`ifndef ALU_ARB_FIXED_PRIO_EN
        prio = 1 - g;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] vld,
                          input int a0, input int b0, input int op0,
                          input int a1, input int b1, input int op1,
                          input int hold);
        int g;
        int ey;
        logic [1:0] oh;
        req_valid_i = vld;
        req_a_i[0] = W'(a0); req_b_i[0] = W'(b0); req_op_i[0] = 3'(op0);
        req_a_i[1] = W'(a1); req_b_i[1] = W'(b1); req_op_i[1] = 3'(op1);
        rsp_ready_i = 2'b00;
        g  = next_grant(vld);
        oh = (g == 1) ? 2'b10 : 2'b01;
        ey = (g == 1) ? alu_ref(a1, b1, op1) : alu_ref(a0, b0, op0);
        #1;
        chk("req_ready_idle", 32'(req_ready_o), 32'(oh));
        chk("busy_idle", 32'(busy_o), 0);
        tick();
        note_grant(g);
        req_a_i[0] = W'($urandom); req_b_i[0] = W'($urandom); req_op_i[0] = 3'($urandom);
        req_a_i[1] = W'($urandom); req_b_i[1] = W'($urandom); req_op_i[1] = 3'($urandom);
        #1;
        chk("busy_exec", 32'(busy_o), 1);
        chk("req_ready_exec", 32'(req_ready_o), 0);
        chk("rsp_valid_exec", 32'(rsp_valid_o), 0);
        tick();
        chk("rsp_valid_resp", 32'(rsp_valid_o), 32'(oh));
        chk("rsp_y", 32'(rsp_y_o), 32'(ey));
        for (int i = 0; i < hold; i++) begin
            rsp_ready_i = ~oh;
            req_valid_i = 2'b11;
            tick();
            chk("rsp_valid_hold", 32'(rsp_valid_o), 32'(oh));
            chk("rsp_y_hold", 32'(rsp_y_o), 32'(ey));
            chk("req_ready_hold", 32'(req_ready_o), 0);
            chk("busy_hold", 32'(busy_o), 1);
        end
        rsp_ready_i = oh;
        tick();
        exp_cnt[g] = (exp_cnt[g] + 1) % 256;
        chk("rsp_valid_done", 32'(rsp_valid_o), 0);
        chk("busy_done", 32'(busy_o), 0);
        chk("done_cnt0", 32'(done_cnt_o[0]), 32'(exp_cnt[0]));
        chk("done_cnt1", 32'(done_cnt_o[1]), 32'(exp_cnt[1]));
        $display("op vld=%b grant=%0d y=%0h cnt0=%0d cnt1=%0d", vld, g, ey, exp_cnt[0], exp_cnt[1]);
        rsp_ready_i = 2'b00;
        req_valid_i = 2'b00;
    endtask

    initial begin
        int g;
        exp_cnt[0] = 0; exp_cnt[1] = 0; prio = 0;
        rst_n = 1'b0;
        req_valid_i = 2'b00; rsp_ready_i = 2'b00;
        req_a_i = '0; req_b_i = '0; req_op_i = '0;
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_rsp_y", 32'(rsp_y_o), 0);
        chk("rst_done_cnt0", 32'(done_cnt_o[0]), 0);
        chk("rst_done_cnt1", 32'(done_cnt_o[1]), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_req_ready", 32'(req_ready_o), 0);
        #10 rst_n = 1'b1;
        tick();

        run_op(2'b01, 9, 3, 0, 0, 0, 0, 0);
        run_op(2'b10, 0, 0, 0, 10, 7, 6, 10);
        for (int n = 0; n < 20; n++) begin
            run_op(2'($urandom_range(1, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)));
        end

        // Both requesters valid continuously with responses always consumed.
        req_valid_i = 2'b11; rsp_ready_i = 2'b11;
        req_a_i[0] = 4'd13; req_b_i[0] = 4'd11; req_op_i[0] = 3'd1;
        req_a_i[1] = 4'd5;  req_b_i[1] = 4'd11; req_op_i[1] = 3'd3;
        g = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k % 3 == 0) begin
                g = next_grant(2'b11);
                chk("stream_req_ready", 32'(req_ready_o), (g == 1) ? 2 : 1);
                note_grant(g);
            end else if (k % 3 == 1) begin
                chk("stream_busy", 32'(busy_o), 1);
                chk("stream_req_ready_low", 32'(req_ready_o), 0);
            end else begin
                chk("stream_rsp_valid", 32'(rsp_valid_o), (g == 1) ? 2 : 1);
                chk("stream_rsp_y", 32'(rsp_y_o), (g == 1) ? alu_ref(5, 11, 3) : alu_ref(13, 11, 1));
                exp_cnt[g] = (exp_cnt[g] + 1) % 256;
                $display("stream grant=%0d cnt0=%0d cnt1=%0d", g, exp_cnt[0], exp_cnt[1]);
            end
            tick();
        end
        req_valid_i = 2'b00; rsp_ready_i = 2'b00;
        #1;
        chk("stream_done_cnt0", 32'(done_cnt_o[0]), 32'(exp_cnt[0]));
        chk("stream_done_cnt1", 32'(done_cnt_o[1]), 32'(exp_cnt[1]));
        tick();

        // Reset asserted while an operation is in EXEC.
        req_valid_i = 2'b01;
        req_a_i[0] = 4'd7; req_b_i[0] = 4'd2; req_op_i[0] = 3'd2;
        tick();
        chk("pre_rst_busy", 32'(busy_o), 1);
        #1 rst_n = 1'b0; req_valid_i = 2'b00;
        exp_cnt[0] = 0; exp_cnt[1] = 0; prio = 0;
        #1;
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("midrst_rsp_y", 32'(rsp_y_o), 0);
        chk("midrst_done_cnt0", 32'(done_cnt_o[0]), 0);
        chk("midrst_done_cnt1", 32'(done_cnt_o[1]), 0);
        #1 rst_n = 1'b1;
        tick();
        chk("postrst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("postrst_busy", 32'(busy_o), 0);
        tick();
        chk("postrst_rsp_valid2", 32'(rsp_valid_o), 0);
        $display("reset during EXEC: no response delivered");

        run_op(2'b11, 3, 4, 0, 6, 2, 1, 0);

        for (int n = 0; n < 256; n++) begin
            run_op(2'b01, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)), 0, 0, 0, 0);
        end
        chk("wrap_done_cnt0", 32'(done_cnt_o[0]), 1);
        chk("wrap_done_cnt1", 32'(done_cnt_o[1]), 32'(exp_cnt[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
